// File: rtl/raw_frame_sched_if.sv
// Scheduler control/status bundle: run control, staged config, timing
// strobes from the video timing generator, and per-frame selections.
interface raw_frame_sched_if #(
    parameter int FCNT_W = 16
);
    // run control and staged configuration
    logic              i_start;
    logic              i_abort;
    logic [FCNT_W-1:0] i_num_frames;
    logic              i_auto;
    logic              i_cfg_wr;
    logic [2:0]        i_cfg_pat;
    logic [1:0]        i_cfg_bayer;
    // timing strobes
    logic              i_vsync;
    logic              i_de;
    logic              i_valid;
    // per-frame selections and status
    logic              o_gen_en;
    logic [2:0]        o_pat_sel;
    logic [1:0]        o_bayer_sel;
    logic [FCNT_W-1:0] o_frame_cnt;
    logic              o_busy;
    logic              o_done;
    logic [1:0]        o_err;

    // drives the scheduler (bench / system controller)
    modport master (
        output i_start, i_abort, i_num_frames, i_auto, i_cfg_wr, i_cfg_pat, i_cfg_bayer,
        output i_vsync, i_de, i_valid,
        input  o_gen_en, o_pat_sel, o_bayer_sel, o_frame_cnt, o_busy, o_done, o_err
    );

    // the scheduler itself
    modport slave (
        input  i_start, i_abort, i_num_frames, i_auto, i_cfg_wr, i_cfg_pat, i_cfg_bayer,
        input  i_vsync, i_de, i_valid,
        output o_gen_en, o_pat_sel, o_bayer_sel, o_frame_cnt, o_busy, o_done, o_err
    );
endinterface

// File: rtl/raw_frame_sched.sv
// Frame-level scheduler for the Bayer test path. Arms on a start pulse,
// runs a fixed number of frames delimited by vsync falling edges, picks
// pattern/Bayer phase per frame (stable for the whole frame), gates the
// pattern generator and checks active line/frame geometry.
module raw_frame_sched #(
    parameter int FCNT_W     = 16,
    parameter int X_ACT_WID  = 12,
    parameter int Y_ACT_WID  = 12,
    parameter int NUM_PAT    = 5,
    parameter int EXP_HBEATS = 240,
    parameter int EXP_VLINES = 270
) (
    input  logic          i_pclk,
    input  logic          i_rstn,
    raw_frame_sched_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

    localparam logic [2:0]           PAT_MAX = 3'(NUM_PAT - 1);
    localparam logic [X_ACT_WID-1:0] H_EXP   = X_ACT_WID'(EXP_HBEATS);
    localparam logic [Y_ACT_WID-1:0] V_EXP   = Y_ACT_WID'(EXP_VLINES);

    state_t              r_state, w_state_next;
    logic                r_vsync_d, r_de_d;
    logic [FCNT_W-1:0]   r_num_frames, r_frame_cnt;
    logic [2:0]          r_cfg_pat, r_pat_sel, w_pat_load;
    logic [1:0]          r_cfg_bayer, r_bayer_sel;
    logic                r_gen_en;
    logic [1:0]          r_err;
    logic [X_ACT_WID-1:0] r_hcnt;
    logic [Y_ACT_WID-1:0] r_vcnt;

    logic w_fb, w_de_fall, w_beat;
    logic w_start_ok, w_load_first, w_load_next, w_finish;

    // frame boundary = vsync falling edge; line end = de falling edge
    assign w_fb      = r_vsync_d && !bus.i_vsync;
    assign w_de_fall = r_de_d && !bus.i_de;
    assign w_beat    = bus.i_de && bus.i_valid;

    // next state and one-cycle action strobes; abort overrides everything
    always_comb begin
        w_state_next = r_state;
        w_start_ok   = 1'b0;
        w_load_first = 1'b0;
        w_load_next  = 1'b0;
        w_finish     = 1'b0;
        if (bus.i_abort && (r_state != S_IDLE)) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (bus.i_start) begin
                    w_state_next = S_ARM;
                    w_start_ok   = 1'b1;
                end
                S_ARM: if (w_fb) begin
                    w_state_next = S_RUN;
                    w_load_first = 1'b1;
                end
                S_RUN: if (w_fb) begin
                    if (r_frame_cnt >= r_num_frames) begin
                        w_state_next = S_DONE;
                        w_finish     = 1'b1;
                    end else begin
                        w_load_next = 1'b1;
                    end
                end
                S_DONE: w_state_next = S_IDLE;
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    // pattern chosen for the frame that starts at this boundary
    always_comb begin
        w_pat_load = r_pat_sel;
        if (bus.i_auto) begin
            if (w_load_first || (r_pat_sel >= PAT_MAX))
                w_pat_load = 3'd0;
            else
                w_pat_load = r_pat_sel + 3'd1;
        end else begin
            w_pat_load = (r_cfg_pat > PAT_MAX) ? PAT_MAX : r_cfg_pat;
        end
    end

    // run control: state, edge detectors, staged config, per-frame selections
    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state      <= S_IDLE;
            r_vsync_d    <= 1'b0;
            r_de_d       <= 1'b0;
            r_cfg_pat    <= '0;
            r_cfg_bayer  <= '0;
            r_num_frames <= '0;
            r_frame_cnt  <= '0;
            r_pat_sel    <= '0;
            r_bayer_sel  <= '0;
            r_gen_en     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_vsync_d <= bus.i_vsync;
            r_de_d    <= bus.i_de;
            // a write coincident with a boundary lands after that boundary's load
            if (bus.i_cfg_wr) begin
                r_cfg_pat   <= bus.i_cfg_pat;
                r_cfg_bayer <= bus.i_cfg_bayer;
            end
            if (bus.i_abort && (r_state != S_IDLE))
                r_gen_en <= 1'b0;
            if (w_start_ok) begin
                r_num_frames <= (bus.i_num_frames == '0) ? FCNT_W'(1) : bus.i_num_frames;
                r_frame_cnt  <= '0;
            end
            if (w_load_first || w_load_next) begin
                r_frame_cnt <= w_load_first ? FCNT_W'(1) : (r_frame_cnt + FCNT_W'(1));
                r_gen_en    <= 1'b1;
                r_pat_sel   <= w_pat_load;
                r_bayer_sel <= r_cfg_bayer;
            end
            if (w_finish)
                r_gen_en <= 1'b0;
        end
    end

    // geometry check: beats per line and lines per frame while running
    always_ff @(posedge i_pclk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_err  <= '0;
        end else if (w_start_ok) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
            r_err  <= '0;
        end else begin
            if (r_state == S_RUN) begin
                if (w_de_fall) begin
                    if (r_hcnt != H_EXP)
                        r_err[0] <= 1'b1;
                    r_hcnt <= '0;
                    if (r_vcnt != '1)
                        r_vcnt <= r_vcnt + Y_ACT_WID'(1);
                end else if (w_beat && (r_hcnt != '1)) begin
                    r_hcnt <= r_hcnt + X_ACT_WID'(1);
                end
                // the ARM->RUN boundary is never checked: state is ARM there
                if (w_fb && !bus.i_abort && (r_vcnt != V_EXP))
                    r_err[1] <= 1'b1;
            end
            if (w_fb)
                r_vcnt <= '0;
        end
    end

    assign bus.o_gen_en    = r_gen_en;
    assign bus.o_pat_sel   = r_pat_sel;
    assign bus.o_bayer_sel = r_bayer_sel;
    assign bus.o_frame_cnt = r_frame_cnt;
    assign bus.o_busy      = (r_state == S_ARM) || (r_state == S_RUN);
    assign bus.o_done      = (r_state == S_DONE) && !bus.i_abort;
    assign bus.o_err       = r_err;
endmodule

// File: tb/tb_raw_frame_sched.sv
// Directed bench for raw_frame_sched: small frame geometry (8 beats x 6
// lines), a run-level reference model checked every cycle, and literal
// expectations at frame boundaries.
module tb_raw_frame_sched;
    localparam int FCNT_W  = 16;
    localparam int NUM_PAT = 5;
    localparam int EXP_H   = 8;
    localparam int EXP_V   = 6;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    raw_frame_sched_if #(.FCNT_W(FCNT_W)) bus ();

    raw_frame_sched #(
        .FCNT_W(FCNT_W), .X_ACT_WID(12), .Y_ACT_WID(12), .NUM_PAT(NUM_PAT),
        .EXP_HBEATS(EXP_H), .EXP_VLINES(EXP_V)
    ) dut (
        .i_pclk(clk),
        .i_rstn(rstn),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- run-level reference model ----------------
    bit       m_armed, m_running, m_donecyc, m_gen, m_pvs, m_pde;
    int       m_target, m_fcnt, m_pat, m_bayer, m_stage_pat, m_stage_bayer, m_beats, m_lines;
    bit [1:0] m_err;

    function automatic int clamp_pat(input int p);
        return (p > NUM_PAT - 1) ? NUM_PAT - 1 : p;
    endfunction

    task automatic model_reset();
        m_armed = 0; m_running = 0; m_donecyc = 0; m_gen = 0; m_pvs = 0; m_pde = 0;
        m_target = 0; m_fcnt = 0; m_pat = 0; m_bayer = 0;
        m_stage_pat = 0; m_stage_bayer = 0; m_beats = 0; m_lines = 0; m_err = 0;
    endtask

    task automatic model_step();
        bit fb, dfall, idle;
        fb    = m_pvs && !bus.i_vsync;
        dfall = m_pde && !bus.i_de;
        idle  = !(m_armed || m_running || m_donecyc);
        // geometry is only judged inside a running frame
        if (m_running) begin
            if (dfall) begin
                if (m_beats != EXP_H) m_err[0] = 1'b1;
                m_beats = 0;
                m_lines++;
            end else if (bus.i_de && bus.i_valid) begin
                m_beats++;
            end
            if (fb && !bus.i_abort && m_lines != EXP_V) m_err[1] = 1'b1;
        end
        if (fb) m_lines = 0;
        // run progression
        if (bus.i_abort && !idle) begin
            m_armed = 0; m_running = 0; m_donecyc = 0; m_gen = 0;
        end else if (m_donecyc) begin
            m_donecyc = 0;
        end else if (idle && bus.i_start) begin
            m_armed  = 1;
            m_target = (bus.i_num_frames == 0) ? 1 : int'(bus.i_num_frames);
            m_fcnt = 0; m_err = 0; m_beats = 0; m_lines = 0;
        end else if (fb && m_armed) begin
            m_armed = 0; m_running = 1; m_gen = 1; m_fcnt = 1;
            m_pat   = bus.i_auto ? 0 : clamp_pat(m_stage_pat);
            m_bayer = m_stage_bayer;
        end else if (fb && m_running) begin
            if (m_fcnt == m_target) begin
                m_running = 0; m_gen = 0; m_donecyc = 1;
            end else begin
                m_fcnt++;
                m_pat   = bus.i_auto ? (m_pat + 1) % NUM_PAT : clamp_pat(m_stage_pat);
                m_bayer = m_stage_bayer;
            end
        end
        if (bus.i_cfg_wr) begin
            m_stage_pat   = int'(bus.i_cfg_pat);
            m_stage_bayer = int'(bus.i_cfg_bayer);
        end
        m_pvs = bus.i_vsync;
        m_pde = bus.i_de;
    endtask

    // compare process: model advances on the edge, DUT is sampled 1 unit later
    always @(posedge clk) begin
        logic [25:0] exp_v, act_v;
        if (!rstn) model_reset();
        else       model_step();
        #1;
        exp_v = {m_gen, 3'(m_pat), 2'(m_bayer), 16'(m_fcnt), (m_armed || m_running),
                 (m_donecyc && !bus.i_abort), m_err};
        act_v = {bus.o_gen_en, bus.o_pat_sel, bus.o_bayer_sel, bus.o_frame_cnt, bus.o_busy,
                 bus.o_done, bus.o_err};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL model_cycle t=%0t got gen=%0b pat=%0d bay=%0d fcnt=%0d busy=%0b done=%0b err=%0b expected gen=%0b pat=%0d bay=%0d fcnt=%0d busy=%0b done=%0b err=%0b",
                     $time, act_v[25], act_v[24:22], act_v[21:20], act_v[19:4], act_v[3], act_v[2], act_v[1:0],
                     exp_v[25], exp_v[24:22], exp_v[21:20], exp_v[19:4], exp_v[3], exp_v[2], exp_v[1:0]);
        end
        if (bus.o_done === 1'b1) done_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic pulse_start();
        bus.i_start = 1'b1;
        @(negedge clk);
        bus.i_start = 1'b0;
    endtask

    task automatic cfg_write(input logic [2:0] p, input logic [1:0] b);
        bus.i_cfg_wr = 1'b1; bus.i_cfg_pat = p; bus.i_cfg_bayer = b;
        @(negedge clk);
        bus.i_cfg_wr = 1'b0;
    endtask

    // One frame: vsync pulse, boundary cycle, then nlines lines of 10 de
    // cycles with 2 valid gaps (8 beats); drop_line loses one extra beat.
    task automatic frame(input int nlines, input int drop_line, input bit wr_fb,
                         input logic [2:0] wp, input logic [1:0] wb, input bit ab_fb,
                         output logic done_seen);
        bus.i_vsync = 1'b1;
        repeat (4) @(negedge clk);
        bus.i_vsync = 1'b0;
        if (wr_fb) begin
            bus.i_cfg_wr = 1'b1; bus.i_cfg_pat = wp; bus.i_cfg_bayer = wb;
        end
        bus.i_abort = ab_fb;
        @(negedge clk);
        done_seen    = bus.o_done;
        bus.i_cfg_wr = 1'b0;
        bus.i_abort  = 1'b0;
        repeat (2) @(negedge clk);
        for (int l = 0; l < nlines; l++) begin
            for (int k = 0; k < 10; k++) begin
                bus.i_de    = 1'b1;
                bus.i_valid = !(k == 3 || k == 7) && !(l == drop_line && k == 5);
                @(negedge clk);
            end
            bus.i_de = 1'b0; bus.i_valid = 1'b0;
            repeat (3) @(negedge clk);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic d;
        int   d0;
        bus.i_start = 0; bus.i_abort = 0; bus.i_num_frames = 0; bus.i_auto = 0;
        bus.i_cfg_wr = 0; bus.i_cfg_pat = 0; bus.i_cfg_bayer = 0;
        bus.i_vsync = 0; bus.i_de = 0; bus.i_valid = 0;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset gen_en", bus.o_gen_en, 0);
        chk("reset busy", bus.o_busy, 0);
        chk("reset frame_cnt", bus.o_frame_cnt, 0);
        chk("reset err", bus.o_err, 0);
        rstn = 1'b1;
        @(negedge clk);

        // auto run of 5 frames, one stray start mid-run
        $display("T auto5 run");
        bus.i_auto = 1; bus.i_num_frames = 5;
        pulse_start();
        chk("arm busy", bus.o_busy, 1);
        chk("arm gen_en", bus.o_gen_en, 0);
        for (int f = 1; f <= 5; f++) begin
            frame(EXP_V, -1, 0, 0, 0, 0, d);
            chk("auto pat", bus.o_pat_sel, f - 1);
            chk("auto fcnt", bus.o_frame_cnt, f);
            chk("auto gen_en", bus.o_gen_en, 1);
            chk("auto no done", d, 0);
            if (f == 3) pulse_start();
        end
        d0 = done_cnt;
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        chk("auto done after 6th fb", d, 1);
        chk("auto done pulses", done_cnt - d0, 1);
        chk("auto end busy", bus.o_busy, 0);
        chk("auto end gen_en", bus.o_gen_en, 0);
        chk("auto end fcnt", bus.o_frame_cnt, 5);
        chk("auto end err", bus.o_err, 0);

        // manual staging, including a write coincident with a boundary
        $display("T manual staging");
        bus.i_auto = 0; bus.i_num_frames = 3;
        pulse_start();
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        chk("man f1 pat", bus.o_pat_sel, 0);
        cfg_write(3'd3, 2'd2);
        chk("man midframe pat", bus.o_pat_sel, 0);
        chk("man midframe bayer", bus.o_bayer_sel, 0);
        frame(EXP_V, -1, 1, 3'd1, 2'd2, 0, d);
        chk("man f2 pat", bus.o_pat_sel, 3);
        chk("man f2 bayer", bus.o_bayer_sel, 2);
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        chk("man f3 pat", bus.o_pat_sel, 1);
        chk("man f3 bayer", bus.o_bayer_sel, 2);
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        chk("man done", d, 1);

        // num_frames=0 runs one frame; out-of-range pattern saturates
        $display("T nf0 saturate");
        bus.i_num_frames = 0;
        cfg_write(3'd6, 2'd3);
        pulse_start();
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        chk("sat pat", bus.o_pat_sel, 4);
        chk("sat bayer", bus.o_bayer_sel, 3);
        chk("nf0 fcnt", bus.o_frame_cnt, 1);
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        chk("nf0 done", d, 1);

        // dropped beat on line 3 of frame 2
        $display("T dropped beat");
        bus.i_auto = 1; bus.i_num_frames = 3;
        pulse_start();
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        chk("drop f1 err", bus.o_err, 0);
        frame(EXP_V, 3, 0, 0, 0, 0, d);
        chk("drop f2 err", bus.o_err, 1);
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        chk("drop done", d, 1);
        chk("drop err held", bus.o_err, 1);

        // short frames: line error only from the second boundary on
        $display("T short frames");
        bus.i_num_frames = 2;
        pulse_start();
        chk("start clears err", bus.o_err, 0);
        frame(EXP_V - 1, -1, 0, 0, 0, 0, d);
        chk("short f1 err", bus.o_err, 0);
        frame(EXP_V - 1, -1, 0, 0, 0, 0, d);
        chk("short f2 err", bus.o_err, 2);
        frame(EXP_V - 1, -1, 0, 0, 0, 0, d);
        chk("short done", d, 1);
        chk("short err held", bus.o_err, 2);

        // abort in ARM, then abort coincident with a boundary in RUN
        $display("T abort");
        bus.i_num_frames = 5;
        pulse_start();
        bus.i_abort = 1; @(negedge clk); bus.i_abort = 0;
        chk("abort arm busy", bus.o_busy, 0);
        pulse_start();
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        chk("abort pre fcnt", bus.o_frame_cnt, 2);
        d0 = done_cnt;
        frame(EXP_V, -1, 0, 0, 0, 1, d);
        chk("abort no done", done_cnt - d0, 0);
        chk("abort busy", bus.o_busy, 0);
        chk("abort gen_en", bus.o_gen_en, 0);
        chk("abort fcnt", bus.o_frame_cnt, 2);
        chk("abort pat held", bus.o_pat_sel, 1);

        // asynchronous reset in the middle of frame 2
        $display("T reset mid run");
        pulse_start();
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        rstn = 1'b0;
        #1;
        chk("rst gen_en", bus.o_gen_en, 0);
        chk("rst pat", bus.o_pat_sel, 0);
        chk("rst fcnt", bus.o_frame_cnt, 0);
        chk("rst busy", bus.o_busy, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        frame(EXP_V, -1, 0, 0, 0, 0, d);
        chk("post rst idle busy", bus.o_busy, 0);
        chk("post rst gen_en", bus.o_gen_en, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
